cache_valid_scanner: RTL and testbench
======================================

# cache_valid_scanner

Sequential 32→5 index encoder for the cache-tag logic, the inverse direction of the tag one-hot demux. It latches a 32-bit multi-hot line vector (valid, dirty or flush-select bits, one per 16-byte cache block) and emits the 5-bit index of every set bit, lowest first, one per accepted handshake. It drives the cache flush/fill sequencer, which needs line numbers rather than one-hot selects.

## Interface
Parameters:
- LINES, 32, number of cache lines (fixed at 32 by the cache geometry)
- INDEX_W, 5, index width, log2(LINES)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  load vector_in and begin a scan; honoured only in IDLE
- vector_in  in  32  multi-hot line vector, sampled on the start cycle
- busy  out  1  high in SCAN and DONE
- index_valid  out  1  index_out holds a pending line index
- index_out  out  5  index of the lowest set bit still pending; 0 when index_valid is low
- index_ready  in  1  consumer accepts index_out this cycle
- done  out  1  one-cycle pulse at end of scan
- count  out  6  indices accepted in the current/last scan, range 0..32

## Operation
- Registers: pending[31:0], state, count[5:0].
- IDLE:
  - start=1 → pending ← vector_in, count ← 0.
  - Next state is SCAN if vector_in≠0, else DONE.
- SCAN:
  - index_valid = (pending≠0).
  - index_out = priority encode of pending, lowest set bit wins.
  - On index_valid & index_ready: clear pending[index_out] and increment count.
  - If that bit was the last set bit, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. count holds its value until the next start.
- start outside IDLE: ignored. pending is not reloaded.
- index_ready while index_valid=0: ignored.
- Stability rule: while index_valid=1 and index_ready=0, index_out and pending stay stable.
- Reset, including in mid-scan:
  - state=IDLE, pending=0, count=0.
  - All outputs go low or zero immediately. No done pulse.
- Outputs are decoded from registers only. There is no combinational path from start, vector_in or index_ready to any output.

## Timing
- Reset values: busy=0, index_valid=0, index_out=0, done=0, count=0.
- start sampled at edge N:
  - The first index_valid appears in cycle N+1.
  - For a zero vector, done appears in cycle N+1 instead.
- Throughput: with index_ready held at 1, one index per cycle.
  - A vector with k set bits gives indices in cycles N+1..N+k.
  - done follows in cycle N+k+1.
  - A new start is accepted from cycle N+k+2.
- count updates on the edge that accepts the handshake. After the last accept, count=k.
- Wrap/width: count is 6 bits wide so that 32 fits. Indices never exceed 31.

## Structure
- Shared cache package holds CACHE_LINES=32, CACHE_INDEX_W=5, CACHE_BLOCK_BYTES=16, and the scanner state encoding (IDLE, SCAN, DONE).
- One sub-module, priority_encoder_32: purely combinational.
  - Inputs: a 32-bit vector.
  - Outputs: a 5-bit lowest-set-bit index plus a nonzero flag.
  - The flag serves as index_valid.
- The FSM, pending register, clear logic and count live in cache_valid_scanner.

## Test plan
- vector_in=0x00000001, start, index_ready=1 → cycle N+1: index_valid=1, index_out=0. Cycle N+2: done=1, count=1. Cycle N+3: busy=0.
- vector_in=0x80000001, index_ready=1 → indices 0 then 31 in consecutive cycles, then done, count=2.
- vector_in=0xFFFFFFFF, index_ready=1 → indices 0,1,…,31 over 32 consecutive cycles, done in cycle N+33, count=32.
- vector_in=0x00000104, index_ready low for 3 cycles:
  - index_out=2 is held stable with index_valid=1.
  - Then ready=1 → index 2 is accepted, then index 8, then done, count=2.
- vector_in=0 → index_valid never asserts, done=1 in cycle N+1, count=0.
- Control hazards:
  - Start 0x0000000F with ready=1. Assert start with vector 0xFFFF0000 in cycle N+2 → ignored; scan completes with count=4.
  - Repeat the scan and assert rst in cycle N+2 → all outputs go to 0 at once, no done pulse. A start after reset works normally.

Source files
------------

// File: rtl/cache_valid_scanner_pkg.sv
// Shared cache geometry constants and the line-scanner state encoding.
package cache_valid_scanner_pkg;

  localparam int CACHE_LINES       = 32;
  localparam int CACHE_INDEX_W     = 5;
  localparam int CACHE_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/cache_valid_scanner_priority_encoder_32.sv
// Combinational 32-bit lowest-set-bit encoder with a nonzero flag.
module priority_encoder_32
  import cache_valid_scanner_pkg::*;
(
  input  logic [CACHE_LINES-1:0]   vec,
  output logic [CACHE_INDEX_W-1:0] index,
  output logic                     nonzero
);

  always_comb begin
    index   = '0;
    nonzero = |vec;
    // Walk from the top down so the lowest set bit is the last write.
    for (int unsigned i = 0; i < CACHE_LINES; i++) begin
      if (vec[CACHE_LINES-1-i]) begin
        index = CACHE_INDEX_W'(CACHE_LINES - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cache_valid_scanner.sv
// Sequential multi-hot to index scanner: emits each set line number, lowest first.
module cache_valid_scanner
  import cache_valid_scanner_pkg::*;
#(
  parameter int LINES   = CACHE_LINES,
  parameter int INDEX_W = CACHE_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LINES-1:0]   vector_in,
  output logic               busy,
  output logic               index_valid,
  output logic [INDEX_W-1:0] index_out,
  input  logic               index_ready,
  output logic               done,
  output logic [INDEX_W:0]   count
);

  scan_state_e        state_q, state_d;
  logic [LINES-1:0]   pending_q, pending_d;
  logic [INDEX_W:0]   count_q, count_d;

  logic [INDEX_W-1:0] enc_index;
  logic               enc_nonzero;
  logic [LINES-1:0]   cleared;

  priority_encoder_32 u_enc (
    .vec     (pending_q),
    .index   (enc_index),
    .nonzero (enc_nonzero)
  );

  assign cleared = pending_q & ~(LINES'(1) << enc_index);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pending_d = vector_in;
          count_d   = '0;
          state_d   = (vector_in != '0) ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        if (enc_nonzero && index_ready) begin
          pending_d = cleared;
          count_d   = count_q + (INDEX_W+1)'(1);
          if (cleared == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    index_valid = (state_q == ST_SCAN) && enc_nonzero;
    index_out   = index_valid ? enc_index : '0;
    done        = (state_q == ST_DONE);
    count       = count_q;
  end

endmodule

// File: tb/tb_cache_valid_scanner.sv
// Directed self-checking bench for cache_valid_scanner.
module tb_cache_valid_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] vector_in;
  logic        busy;
  logic        index_valid;
  logic [4:0]  index_out;
  logic        index_ready;
  logic        done;
  logic [5:0]  count;

  int unsigned n_checks;
  int unsigned n_fail;

  cache_valid_scanner #(.LINES(32), .INDEX_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vector_in   (vector_in),
    .busy        (busy),
    .index_valid (index_valid),
    .index_out   (index_out),
    .index_ready (index_ready),
    .done        (done),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  32'(busy),        32'd0);
    check({tag, ".valid"}, 32'(index_valid), 32'd0);
    check({tag, ".idx"},   32'(index_out),   32'd0);
    check({tag, ".done"},  32'(done),        32'd0);
  endtask

  // Full-throughput scan with ready held high; expected indices from the vector.
  task automatic run_scan(input logic [31:0] vec);
    int unsigned k;
    k = 0;
    index_ready = 1'b1;
    vector_in   = vec;
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) begin
        check("scan.busy",  32'(busy),        32'd1);
        check("scan.valid", 32'(index_valid), 32'd1);
        check("scan.idx",   32'(index_out),   32'(i));
        check("scan.cnt",   32'(count),       32'(k));
        k++;
        step();
      end
    end
    check("scan.done",      32'(done),        32'd1);
    check("scan.donevalid", 32'(index_valid), 32'd0);
    check("scan.count",     32'(count),       32'(k));
    step();
    check_idle("scan.after");
    check("scan.cnthold", 32'(count), 32'(k));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    start       = 1'b0;
    vector_in   = '0;
    index_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle("reset");
    check("reset.count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single bit: exact cycle placement of index, done and idle.
    index_ready = 1'b1;
    vector_in   = 32'h0000_0001;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("one.busy",  32'(busy),        32'd1);
    check("one.valid", 32'(index_valid), 32'd1);
    check("one.idx",   32'(index_out),   32'd0);
    check("one.done",  32'(done),        32'd0);
    step();
    check("one.done2", 32'(done),        32'd1);
    check("one.count", 32'(count),       32'd1);
    check("one.valid2",32'(index_valid), 32'd0);
    step();
    check("one.busy3", 32'(busy),        32'd0);
    check("one.done3", 32'(done),        32'd0);

    run_scan(32'h8000_0001);
    run_scan(32'hFFFF_FFFF);
    run_scan(32'h0000_0000);
    run_scan(32'h0500_A040);

    // Back-pressure: index 2 must hold while ready is low.
    index_ready = 1'b0;
    vector_in   = 32'h0000_0104;
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall.valid", 32'(index_valid), 32'd1);
      check("stall.idx",   32'(index_out),   32'd2);
      check("stall.count", 32'(count),       32'd0);
      step();
    end
    index_ready = 1'b1;
    check("stall.idx2", 32'(index_out), 32'd2);
    step();
    check("stall.idx8", 32'(index_out), 32'd8);
    check("stall.cnt1", 32'(count),     32'd1);
    step();
    check("stall.done",  32'(done),  32'd1);
    check("stall.count2",32'(count), 32'd2);
    step();
    check_idle("stall.after");

    // start during a scan must not reload pending.
    vector_in = 32'h0000_000F;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("ign.idx0", 32'(index_out), 32'd0);
    step();
    check("ign.idx1", 32'(index_out), 32'd1);
    vector_in = 32'hFFFF_0000;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("ign.idx2", 32'(index_out), 32'd2);
    step();
    check("ign.idx3", 32'(index_out), 32'd3);
    step();
    check("ign.done",  32'(done),  32'd1);
    check("ign.count", 32'(count), 32'd4);
    step();
    check_idle("ign.after");
    check("ign.cnthold", 32'(count), 32'd4);

    // Asynchronous reset mid-scan clears outputs without waiting for an edge.
    vector_in = 32'h0000_000F;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rst.idx1",  32'(index_out), 32'd1);
    check("rst.cnt1",  32'(count),     32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("rst.now");
    check("rst.count", 32'(count), 32'd0);
    step();
    check_idle("rst.held");
    rst = 1'b0;
    step();
    check_idle("rst.post");
    check("rst.count2", 32'(count), 32'd0);

    run_scan(32'h0000_0104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
